// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: initiator-side sequencer for the start/step2/step3 handshake FSM.
// Latency: registered outputs, reacts to sampled status one cycle after it is seen.
// Backpressure: paced by the controlled FSM's status; a watchdog bounds every wait.
//
// Ports:
//   clk, clr_n            rising-edge clock, asynchronous active-low reset
//   go, skip              run request (IDLE only) and step2-decline flag latched with it
//   status[2:0]           controlled FSM code: 001 idle, 010 started, 100 decision, 111 wait
//   start, step2, step3   drives into the controlled FSM
//   busy, done, aborted   run in progress, completed-run pulse, skipped-run pulse
//   err, run_cnt          sticky error flag, wrapping count of completed runs
module fsm_seq_ctrl #(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             go,
  input  logic             skip,
  input  logic [2:0]       status,
  output logic             start,
  output logic             step2,
  output logic             step3,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [CNT_W-1:0] run_cnt
);

  localparam logic [2:0] ST_IDLE    = 3'b001;
  localparam logic [2:0] ST_STARTED = 3'b010;
  localparam logic [2:0] ST_DECIDE  = 3'b100;
  localparam logic [2:0] ST_WAIT    = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DECIDE,
    S_DWELL,
    S_RETURN
  } state_e;

  state_e           state_q;
  logic             start_q, step2_q, step3_q, busy_q;
  logic             done_q, aborted_q, err_q, skip_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [7:0]       wd_q;
  logic [7:0]       dwell_q;
  logic [2:0]       status_prev_q;

  logic       legal_d;
  logic       status_chg_d;
  logic       fail_d;
  logic       wd_tick_d;
  logic       timeout_d;
  logic [8:0] wd_inc_d;
  logic [8:0] dwell_inc_d;

  assign start   = start_q;
  assign step2   = step2_q;
  assign step3   = step3_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign err     = err_q;
  assign run_cnt = run_cnt_q;

  // Classify the sampled status against what the current state expects.
  // fail_d covers both unknown codes and legal codes arriving out of order;
  // wd_tick_d marks the cycles in which the watchdog is counting.
  always_comb begin
    legal_d      = (status == ST_IDLE) || (status == ST_STARTED) ||
                   (status == ST_DECIDE) || (status == ST_WAIT);
    status_chg_d = (status != status_prev_q);
    wd_inc_d     = {1'b0, wd_q} + 9'd1;
    dwell_inc_d  = {1'b0, dwell_q} + 9'd1;
    fail_d       = 1'b0;
    wd_tick_d    = 1'b0;
    case (state_q)
      S_ISSUE: begin
        if (!legal_d || status == ST_DECIDE || status == ST_WAIT) fail_d = 1'b1;
        else if (status == ST_IDLE)                              wd_tick_d = 1'b1;
      end
      S_DECIDE: begin
        // Falling back to idle is only legitimate when step2 was declined.
        if (!legal_d || (status == ST_IDLE && !skip_q))           fail_d = 1'b1;
        else if (status == ST_STARTED || status == ST_DECIDE)     wd_tick_d = 1'b1;
      end
      S_DWELL: begin
        if (status != ST_WAIT) fail_d = 1'b1;
      end
      S_RETURN: begin
        if (status != ST_IDLE && status != ST_WAIT) fail_d = 1'b1;
        else if (status == ST_WAIT)                 wd_tick_d = 1'b1;
      end
      default: ;
    endcase
    // A status change restarts the count instead of advancing it.
    timeout_d = wd_tick_d && !status_chg_d && (wd_inc_d >= 9'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      step2_q       <= 1'b0;
      step3_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      err_q         <= 1'b0;
      skip_q        <= 1'b0;
      run_cnt_q     <= '0;
      wd_q          <= 8'd0;
      dwell_q       <= 8'd0;
      status_prev_q <= ST_IDLE;
    end else begin
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      status_prev_q <= status;

      if (fail_d || timeout_d) begin
        // Error exit: release every drive and leave the FSM to its own clear.
        err_q   <= 1'b1;
        start_q <= 1'b0;
        step2_q <= 1'b0;
        step3_q <= 1'b0;
        busy_q  <= 1'b0;
        wd_q    <= 8'd0;
        state_q <= S_IDLE;
      end else begin
        if (wd_tick_d) wd_q <= status_chg_d ? 8'd0 : wd_inc_d[7:0];

        case (state_q)
          S_IDLE: begin
            if (go && status == ST_IDLE) begin
              skip_q  <= skip;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              step2_q <= ~skip;
              wd_q    <= 8'd0;
              state_q <= S_ISSUE;
            end
          end

          S_ISSUE: begin
            if (status == ST_STARTED) begin
              start_q <= 1'b0;
              wd_q    <= 8'd0;
              state_q <= S_DECIDE;
            end
          end

          S_DECIDE: begin
            if (status == ST_WAIT) begin
              wd_q    <= 8'd0;
              dwell_q <= 8'd0;
              if (DWELL == 0) begin
                step3_q <= 1'b1;
                state_q <= S_RETURN;
              end else begin
                state_q <= S_DWELL;
              end
            end else if (status == ST_IDLE) begin
              // Only reachable with skip latched; the other case is fail_d.
              aborted_q <= 1'b1;
              step2_q   <= 1'b0;
              busy_q    <= 1'b0;
              wd_q      <= 8'd0;
              state_q   <= S_IDLE;
            end
          end

          S_DWELL: begin
            if (dwell_inc_d == 9'(DWELL)) begin
              step3_q <= 1'b1;
              wd_q    <= 8'd0;
              state_q <= S_RETURN;
            end else begin
              dwell_q <= dwell_inc_d[7:0];
            end
          end

          S_RETURN: begin
            if (status == ST_IDLE) begin
              step3_q   <= 1'b0;
              step2_q   <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              run_cnt_q <= run_cnt_q + CNT_W'(1);
              wd_q      <= 8'd0;
              state_q   <= S_IDLE;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
